ram_param_hs: RTL and testbench

Parametrised, synchronous, byte-addressed big-endian data memory with a four-phase MFA/MOC handshake and programmable wait states. It serves the CPU datapath's load/store unit, accepting byte, halfword, word and doubleword accesses over a 64-bit data bus. It adds several behaviours the first-generation RAM lacked:
- clocked operation;
- configurable depth;
- deterministic completion latency;
- range checking, with optional alignment checking.

---
 rtl/ram_param_hs_if.sv | 37 +++
 rtl/ram_param_hs.sv | 156 +++++++++++++++
 tb/tb_ram_param_hs.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_param_hs_if.sv
// ram_param_hs_if: MFA/MOC handshake bus between a load/store requester
// and the ram_param_hs data memory. The requester uses the master modport
// and the memory uses the slave modport.
interface ram_param_hs_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic                  mfa;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] address;
    logic [1:0]            type_data;
    logic [63:0]           data_in;
    logic [63:0]           data_out;
    logic                  moc;
    logic                  err;

    modport master (
        output mfa,
        output rw,
        output address,
        output type_data,
        output data_in,
        input  data_out,
        input  moc,
        input  err
    );

    modport slave (
        input  mfa,
        input  rw,
        input  address,
        input  type_data,
        input  data_in,
        output data_out,
        output moc,
        output err
    );
endinterface

// File: rtl/ram_param_hs.sv
// ram_param_hs: byte-addressed big-endian data memory with a four-phase
// MFA/MOC handshake and WAIT_STATES programmable wait cycles.
// Accesses of 1/2/4/8 bytes, right-justified data, range checking.
// Optional macro RAM_PARAM_HS_ALIGN_CHECK_EN also rejects accesses whose
// address is not a multiple of the access size.
module ram_param_hs #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_param_hs_if.slave  bus
);

    // One extra bit so address + size never wraps around.
    localparam int EW = ADDR_WIDTH + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  lat_rw;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [1:0]            lat_type;
    logic [63:0]           lat_data;

    logic [7:0]            mem [0:DEPTH-1];

    logic [3:0]            nbytes;
    logic [EW-1:0]         last_addr;
    logic                  range_err;
    logic                  align_err;
    logic                  acc_err;
    logic [EW-1:0]         byte_addr [8];
    logic [7:0]            wr_byte [8];
    logic [63:0]           rd_value;
    logic                  complete;
    logic                  mem_we;

    // Decode the latched request: size, last byte touched and legality.
    always_comb begin
        nbytes    = 4'd1 << lat_type;
        last_addr = {1'b0, lat_addr} + EW'(nbytes) - EW'(1);
        range_err = last_addr > EW'(DEPTH - 1);
`ifdef RAM_PARAM_HS_ALIGN_CHECK_EN
        align_err = (lat_addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0;
`else
        align_err = 1'b0;
`endif
        acc_err   = range_err | align_err;
    end

    // Byte lane addresses and big-endian write bytes: lane 0 is the MSB.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            byte_addr[i] = {1'b0, lat_addr} + EW'(i);
            if (4'(i) < nbytes) begin
                wr_byte[i] = 8'(lat_data >> (8 * (int'(nbytes) - 1 - i)));
            end else begin
                wr_byte[i] = 8'h00;
            end
        end
    end

    // Assemble the read value MSB first; unused upper bytes stay zero.
    always_comb begin
        rd_value = 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                if (byte_addr[i] < EW'(DEPTH)) begin
                    rd_value = {rd_value[55:0], mem[byte_addr[i][IW-1:0]]};
                end else begin
                    rd_value = {rd_value[55:0], 8'h00};
                end
            end
        end
    end

    // Completion happens on the edge where BUSY sees mfa held and no wait left.
    always_comb begin
        complete = (state == BUSY) && bus.mfa && (wait_cnt == 4'd0);
        mem_we   = complete && !lat_rw && !acc_err;
    end

    // Storage has no reset; all N bytes of a write land on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < nbytes) begin
                    mem[byte_addr[i][IW-1:0]] <= wr_byte[i];
                end
            end
        end
    end

    // Handshake FSM with registered moc/err/data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            lat_rw       <= 1'b0;
            lat_addr     <= '0;
            lat_type     <= 2'd0;
            lat_data     <= 64'h0;
            bus.moc      <= 1'b0;
            bus.err      <= 1'b0;
            bus.data_out <= 64'h0;
        end else begin
            case (state)
                IDLE: begin
                    bus.moc <= 1'b0;
                    bus.err <= 1'b0;
                    if (bus.mfa) begin
                        lat_rw   <= bus.rw;
                        lat_addr <= bus.address;
                        lat_type <= bus.type_data;
                        lat_data <= bus.data_in;
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.mfa) begin
                        state <= IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        bus.moc <= 1'b1;
                        bus.err <= acc_err;
                        if (lat_rw && !acc_err) begin
                            bus.data_out <= rd_value;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.mfa) begin
                        bus.moc <= 1'b0;
                        bus.err <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_param_hs.sv
// tb_ram_param_hs: three ram_param_hs instances (WAIT_STATES 1, 3, 0)
// sharing one stimulus bus, selected by sel, checked against a byte-array
// reference model. Build with RAM_PARAM_HS_ALIGN_CHECK_EN to exercise
// the alignment-checking variant.
module tb_ram_param_hs;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_n;
    int          sel;
    logic        mfa;
    logic        rw;
    logic [7:0]  address;
    logic [1:0]  typeData;
    logic [63:0] dataIn;

    logic        curMoc;
    logic        curErr;
    logic [63:0] curData;

    int checks;
    int errors;

    logic [7:0]  refMem [3][DEPTH];
    logic [63:0] refOut [3];

    ram_param_hs_if #(.ADDR_WIDTH(8)) bus0 ();
    ram_param_hs_if #(.ADDR_WIDTH(8)) bus1 ();
    ram_param_hs_if #(.ADDR_WIDTH(8)) bus2 ();

    ram_param_hs #(.ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    ram_param_hs #(.ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    ram_param_hs #(.ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    // Only the selected memory sees mfa; all share the other request fields.
    assign bus0.mfa       = mfa && (sel == 0);
    assign bus1.mfa       = mfa && (sel == 1);
    assign bus2.mfa       = mfa && (sel == 2);
    assign bus0.rw        = rw;
    assign bus1.rw        = rw;
    assign bus2.rw        = rw;
    assign bus0.address   = address;
    assign bus1.address   = address;
    assign bus2.address   = address;
    assign bus0.type_data = typeData;
    assign bus1.type_data = typeData;
    assign bus2.type_data = typeData;
    assign bus0.data_in   = dataIn;
    assign bus1.data_in   = dataIn;
    assign bus2.data_in   = dataIn;

    // Observe the responses of whichever memory is selected.
    always_comb begin
        case (sel)
            1: begin
                curMoc = bus1.moc; curErr = bus1.err; curData = bus1.data_out;
            end
            2: begin
                curMoc = bus2.moc; curErr = bus2.err; curData = bus2.data_out;
            end
            default: begin
                curMoc = bus0.moc; curErr = bus0.err; curData = bus0.data_out;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wsOf(input int s);
        case (s)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One full handshake on memory s; the model decides err and data.
    task automatic applyStimulus(input int s, input bit r, input int a,
                                 input int t, input logic [63:0] d,
                                 input bit holdDone);
        int          n;
        int          c;
        bit          expErr;
        logic [63:0] v;
        n      = 1 << t;
        expErr = (a + n - 1) > (DEPTH - 1);
`ifdef RAM_PARAM_HS_ALIGN_CHECK_EN
        if ((a % n) != 0) expErr = 1'b1;
`endif
        @(negedge clk);
        sel      = s;
        rw       = r;
        address  = 8'(a);
        typeData = 2'(t);
        dataIn   = d;
        mfa      = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            rw       = 1'($urandom);
            address  = 8'($urandom);
            typeData = 2'($urandom);
            dataIn   = {$urandom, $urandom};
        end while (!curMoc && c < 40);
        checkOutput("latency", 64'(c), 64'(wsOf(s) + 2));
        if (curMoc) begin
            if (!expErr) begin
                if (!r) begin
                    for (int i = 0; i < n; i++)
                        refMem[s][a + i] = 8'(d >> (8 * (n - 1 - i)));
                end else begin
                    v = 64'h0;
                    for (int i = 0; i < n; i++)
                        v = (v << 8) | 64'(refMem[s][a + i]);
                    refOut[s] = v;
                end
            end
            checkOutput("err", 64'(curErr), 64'(expErr));
            checkOutput("data_out", curData, refOut[s]);
        end
        if (!holdDone) begin
            mfa = 1'b0;
            @(negedge clk);
            checkOutput("moc_fall", 64'(curMoc), 64'h0);
        end
    endtask

    initial begin
        int holdCount;
        logic [63:0] keep;
        checks   = 0;
        errors   = 0;
        sel      = 0;
        mfa      = 1'b0;
        rw       = 1'b0;
        address  = 8'h0;
        typeData = 2'd0;
        dataIn   = 64'h0;
        rst_n    = 1'b0;
        for (int s = 0; s < 3; s++) refOut[s] = 64'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state of every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput("reset_moc", 64'(curMoc), 64'h0);
            checkOutput("reset_err", 64'(curErr), 64'h0);
            checkOutput("reset_data", curData, 64'h0);
        end

        // Fill every memory so the model knows all contents.
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < DEPTH / 8; k++)
                applyStimulus(s, 1'b0, k * 8, 3, {$urandom, $urandom}, 1'b0);

        // Big-endian layout and latency with WAIT_STATES=1.
        applyStimulus(0, 1'b0, 8'h10, 3, 64'h0123_4567_89AB_CDEF, 1'b0);
        applyStimulus(0, 1'b1, 8'h10, 0, 64'h0, 1'b0);
        checkOutput("tp_byte10", curData, 64'h01);
        applyStimulus(0, 1'b1, 8'h14, 2, 64'h0, 1'b0);
        checkOutput("tp_word14", curData, 64'h89AB_CDEF);

        // Range boundary at the top of memory.
        applyStimulus(0, 1'b0, 8'hFF, 1, 64'hBEEF, 1'b0);
        applyStimulus(0, 1'b1, 8'hFF, 0, 64'h0, 1'b0);
        keep = curData;
        applyStimulus(0, 1'b1, 8'hF9, 3, 64'h0, 1'b0);
        checkOutput("tp_range_keep", curData, keep);

        // Unaligned word write and read back.
        applyStimulus(0, 1'b0, 8'h02, 2, 64'hDEAD_BEEF, 1'b0);
        applyStimulus(0, 1'b1, 8'h02, 2, 64'h0, 1'b0);

        // Abort during BUSY with WAIT_STATES=3: no moc, no write.
        @(negedge clk);
        sel      = 1;
        rw       = 1'b0;
        address  = 8'h20;
        typeData = 2'd0;
        dataIn   = 64'h5A;
        mfa      = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort_busy_moc", 64'(curMoc), 64'h0);
        end
        mfa = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("abort_idle_moc", 64'(curMoc), 64'h0);
        end
        applyStimulus(1, 1'b1, 8'h20, 0, 64'h0, 1'b0);

        // mfa held high after completion with WAIT_STATES=0.
        applyStimulus(2, 1'b1, 8'h40, 3, 64'h0, 1'b1);
        holdCount = 0;
        repeat (10) begin
            @(negedge clk);
            if (curMoc) holdCount++;
        end
        checkOutput("hold_moc_cycles", 64'(holdCount), 64'd10);
        mfa = 1'b0;
        @(negedge clk);
        checkOutput("hold_moc_fall", 64'(curMoc), 64'h0);

        // Randomized traffic on all instances, biased toward the top end.
        for (int k = 0; k < 90; k++) begin
            int s;
            int a;
            s = k % 3;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(240, 255))
                                            : int'($urandom_range(0, 255));
            applyStimulus(s, 1'($urandom), a, int'($urandom_range(0, 3)),
                          {$urandom, $urandom}, 1'b0);
        end

        // Reset while in DONE after a read; memory contents survive.
        applyStimulus(0, 1'b0, 8'h30, 3, 64'hFFFF, 1'b0);
        applyStimulus(0, 1'b1, 8'h30, 3, 64'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_moc", 64'(curMoc), 64'h0);
        checkOutput("rst_err", 64'(curErr), 64'h0);
        checkOutput("rst_data", curData, 64'h0);
        mfa = 1'b0;
        for (int s = 0; s < 3; s++) refOut[s] = 64'h0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 8'h30, 3, 64'h0, 1'b0);
        checkOutput("rst_retained", curData, 64'hFFFF);
        applyStimulus(0, 1'b1, 8'h10, 0, 64'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
